// File: rtl/param_splitter_pkg.sv
// Shared types and sizing helpers for the toggle pulse splitter.
// Timestamp width is chosen so that the worst-case scheduling distance never aliases.
package param_splitter_pkg;

  function automatic int ts_width(input int dw, input int depth);
    return dw + $clog2(depth) + 1;
  endfunction

  function automatic int max_delay(input int dw);
    return (1 << dw) - 1;
  endfunction

  localparam int DELAY_W_DEF = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int MAX_DELAY   = max_delay(DELAY_W_DEF);
  localparam int TS_W_DEF    = ts_width(DELAY_W_DEF, DEPTH_DEF);

  typedef struct packed {
    logic [TS_W_DEF-1:0] due_ts;
  } q_entry_t;

endpackage

// File: rtl/param_splitter_if.sv
// Pulse input, per-channel controls and toggle outputs of the splitter.
// master drives stimulus, slave is the splitter itself.
interface param_splitter_if #(
  parameter int N_OUT   = 2,
  parameter int DELAY_W = 4
);
  logic                     in_i;
  logic [N_OUT-1:0]         en_i;
  logic [N_OUT*DELAY_W-1:0] delay_i;
  logic                     clr_ovf_i;
  logic [N_OUT-1:0]         out_o;
  logic [N_OUT-1:0]         busy_o;
  logic [N_OUT-1:0]         overflow_o;

  modport master (
    output in_i, en_i, delay_i, clr_ovf_i,
    input  out_o, busy_o, overflow_o
  );

  modport slave (
    input  in_i, en_i, delay_i, clr_ovf_i,
    output out_o, busy_o, overflow_o
  );
endinterface

// File: rtl/param_splitter_channel.sv
// One output channel: FIFO of due timestamps, ordering counter,
// toggle output, busy and sticky overflow.
module splitter_channel #(
  parameter int DELAY_W = 4,
  parameter int DEPTH   = 4,
  parameter int TS_W    = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pulse_i,
  input  logic               en_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic               clr_ovf_i,
  input  logic [TS_W-1:0]    ts_i,
  output logic               out_o,
  output logic               busy_o,
  output logic               overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TS_W-1:0] fifo_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TS_W-1:0] last_q, last_d;
  logic [TS_W-1:0] rel, dext;
  logic            tog_q, ovf_q;
  logic            empty, full, sched;
  logic            pop, push, bypass, drop;

  always_comb begin
    dext   = TS_W'(delay_i);
    empty  = (cnt_q == '0);
    full   = (cnt_q == CW'(DEPTH));
    sched  = pulse_i & en_i;
    drop   = sched & full;
    pop    = !empty && (fifo_q[rd_q] == ts_i);
    // last_q counts cycles to the newest pending delivery
    if (empty)
      rel = dext;
    else if (dext > last_q)
      rel = dext;
    else
      rel = last_q + TS_W'(1);
    bypass = sched & empty & (rel == '0);
    push   = sched & ~full & ~bypass;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (push)
      last_d = rel - TS_W'(1);
    else if (last_q != '0)
      last_d = last_q - TS_W'(1);
    else
      last_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        fifo_q[k] <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      tog_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      if (push) begin
        fifo_q[wr_q] <= ts_i + rel;
        wr_q         <= wr_q + AW'(1);
      end
      if (pop)
        rd_q <= rd_q + AW'(1);
      if (pop | bypass)
        tog_q <= ~tog_q;
      ovf_q <= drop | (ovf_q & ~clr_ovf_i);
    end
  end

  assign out_o      = tog_q;
  assign busy_o     = (cnt_q != '0);
  assign overflow_o = ovf_q;

endmodule

// File: rtl/param_splitter.sv
// Fans one toggle-encoded pulse stream out to N_OUT delayed,
// order-preserving toggle outputs sharing one timestamp counter.
module param_splitter #(
  parameter int N_OUT   = 2,
  parameter int DELAY_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  param_splitter_if.slave   bus
);
  import param_splitter_pkg::*;

  localparam int TS_W = ts_width(DELAY_W, DEPTH);

  logic            in_q;
  logic [TS_W-1:0] ts_q;
  logic            pulse;
  logic [N_OUT-1:0] out_w, busy_w, ovf_w;

  assign pulse = bus.in_i ^ in_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= 1'b0;
      ts_q <= '0;
    end else begin
      in_q <= bus.in_i;
      ts_q <= ts_q + TS_W'(1);
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_ch
    splitter_channel #(
      .DELAY_W (DELAY_W),
      .DEPTH   (DEPTH),
      .TS_W    (TS_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .pulse_i    (pulse),
      .en_i       (bus.en_i[i]),
      .delay_i    (bus.delay_i[i*DELAY_W +: DELAY_W]),
      .clr_ovf_i  (bus.clr_ovf_i),
      .ts_i       (ts_q),
      .out_o      (out_w[i]),
      .busy_o     (busy_w[i]),
      .overflow_o (ovf_w[i])
    );
  end

  assign bus.out_o      = out_w;
  assign bus.busy_o     = busy_w;
  assign bus.overflow_o = ovf_w;

endmodule

// File: tb/tb_param_splitter.sv
// Scoreboard bench for param_splitter: an edge-level reference model
// of absolute delivery times feeds a queue checked by a monitor.
module tb_param_splitter;
  localparam int N     = 2;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_splitter_if #(.N_OUT(N), .DELAY_W(DW)) bus ();

  param_splitter #(
    .N_OUT   (N),
    .DELAY_W (DW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0] out;
    logic [N-1:0] busy;
    logic [N-1:0] ovf;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  int           mq [N][$];
  logic [N-1:0] m_tog = '0;
  logic [N-1:0] m_ovf = '0;
  logic         m_in_q = 1'b0;
  int           now = 0;

  task automatic chk(input string name, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // reference model: each channel holds absolute edge numbers of its deliveries
  initial forever begin : model
    logic pulse;
    logic drop;
    int   d;
    int   rel;
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      m_tog  = '0;
      m_ovf  = '0;
      m_in_q = 1'b0;
    end else begin
      pulse  = (bus.in_i != m_in_q);
      m_in_q = bus.in_i;
      for (int c = 0; c < N; c++) begin
        drop = 1'b0;
        d = int'(bus.delay_i[c*DW +: DW]);
        if (pulse && bus.en_i[c]) begin
          if (mq[c].size() == DEPTH) begin
            drop = 1'b1;
          end else begin
            if (mq[c].size() == 0)
              rel = d;
            else if (d > mq[c][$] - now)
              rel = d;
            else
              rel = mq[c][$] - now + 1;
            mq[c].push_back(now + rel);
          end
        end
        if (mq[c].size() > 0 && mq[c][0] == now) begin
          void'(mq[c].pop_front());
          m_tog[c] = ~m_tog[c];
        end
        m_ovf[c] = drop | (m_ovf[c] & ~bus.clr_ovf_i);
      end
      now++;
    end
    e.out = m_tog;
    e.ovf = m_ovf;
    for (int c = 0; c < N; c++) e.busy[c] = (mq[c].size() > 0);
    exp_q.push_back(e);
  end

  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out", bus.out_o, e.out);
      chk("busy", bus.busy_o, e.busy);
      chk("overflow", bus.overflow_o, e.ovf);
    end
  end

  task automatic drive(input logic inv, input logic [N-1:0] en,
                       input logic [N*DW-1:0] dl, input logic clr);
    @(negedge clk);
    bus.in_i      = inv;
    bus.en_i      = en;
    bus.delay_i   = dl;
    bus.clr_ovf_i = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(bus.in_i, bus.en_i, bus.delay_i, 1'b0);
  endtask

  task automatic pulse(input logic [N-1:0] en, input logic [N*DW-1:0] dl);
    drive(~bus.in_i, en, dl, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    bus.in_i = 1'b0;
    #1;
    chk("rst_out", bus.out_o, '0);
    chk("rst_busy", bus.busy_o, '0);
    chk("rst_ovf", bus.overflow_o, '0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int prob;
    bus.in_i      = 1'b0;
    bus.en_i      = '0;
    bus.delay_i   = '0;
    bus.clr_ovf_i = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // split delays, one pulse
    idle(2);
    pulse(2'b11, 8'h30);
    idle(6);
    // back-to-back pulses, equal delay
    repeat (4) pulse(2'b11, 8'h22);
    idle(5);
    // delay shrinking between pulses
    pulse(2'b11, 8'h55);
    pulse(2'b11, 8'h00);
    idle(8);
    // overflow, clear, then clear colliding with a drop
    repeat (5) pulse(2'b11, 8'hFF);
    idle(18);
    drive(bus.in_i, 2'b11, 8'hFF, 1'b1);
    idle(2);
    repeat (4) pulse(2'b11, 8'hFF);
    drive(~bus.in_i, 2'b11, 8'hFF, 1'b1);
    idle(20);
    drive(bus.in_i, 2'b11, 8'hFF, 1'b1);
    idle(2);
    // disable after first pulse
    pulse(2'b10, 8'h60);
    repeat (3) pulse(2'b01, 8'h60);
    idle(10);
    // reset with pulses in flight
    repeat (3) pulse(2'b11, 8'hAA);
    do_reset(2);
    idle(15);

    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0]    en;
      logic [N*DW-1:0] dl;
      logic            tg;
      case ((i / 500) % 4)
        0: prob = 80;
        1: prob = 30;
        2: prob = 5;
        default: prob = 55;
      endcase
      for (int c = 0; c < N; c++) en[c] = ($urandom_range(0, 7) != 0);
      dl = ($urandom_range(0, 3) == 0) ? N*DW'($urandom) : bus.delay_i;
      tg = ($urandom_range(0, 99) < prob);
      drive(tg ? ~bus.in_i : bus.in_i, en, dl, $urandom_range(0, 15) == 0);
      if (i % 700 == 699) do_reset(1 + i % 3);
    end

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
